// File: rtl/inst_fetch_unit_pkg.sv
// Purpose : shared widths, constants and vectors for the instruction-fetch stage.
// Latency : n/a (definitions only).
// Backpressure: n/a (definitions only).
package inst_fetch_unit_pkg;

  localparam int          INST_ADDR_BUS = 32;
  localparam int          INST_BUS      = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0008;

  // An all-zero word decodes as a nop downstream.
  localparam logic [31:0] NOP_INST = ZERO_WORD;

  // Targets are not alignment-checked; the two low bits are simply dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if_id_reg.sv
// Purpose : IF/ID pipeline register with hold and bubble controls.
// Latency : 1 cycle from i_pc/i_inst to o_id_*.
// Backpressure: i_hold freezes the register; i_bubble loads a nop (valid=0).
// Ports   : clk, rst_n; i_hold, i_bubble (controls); i_pc, i_inst (fetch side);
//           o_id_pc, o_id_inst, o_id_valid (decode side).
module inst_fetch_unit_if_id_reg
  import inst_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hold,
  input  logic        i_bubble,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_inst,
  output logic        o_id_valid
);

  logic [INST_ADDR_BUS-1:0] r_id_pc;
  logic [INST_BUS-1:0]      r_id_inst;
  logic                     r_id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_pc    <= ZERO_WORD;
      r_id_inst  <= ZERO_WORD;
      r_id_valid <= 1'b0;
    end else if (!i_hold) begin
      // A bubble still records the PC of the squashed slot.
      r_id_pc    <= i_pc;
      r_id_inst  <= i_bubble ? NOP_INST : i_inst;
      r_id_valid <= ~i_bubble;
    end
  end

  assign o_id_pc    = r_id_pc;
  assign o_id_inst  = r_id_inst;
  assign o_id_valid = r_id_valid;

endmodule

// File: rtl/inst_fetch_unit.sv
// Purpose : IF stage; owns the PC, drives the instruction ROM, fills IF/ID.
// Latency : 0 cycles PC->ROM (combinational read), 1 cycle ROM->IF/ID.
// Backpressure: stall_i holds PC and IF/ID; a redirect seen during a stall is parked.
// Ports   : clk, rst_n; rom_addr_o/rom_ce_o/rom_data_i (ROM); stall_i, redirect_i,
//           redirect_pc_i, exc_i, irq_i (control); pc_o; id_pc_o/id_inst_o/id_valid_o
//           (IF/ID); epc_o/epc_we_o (interrupt return address write).
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = inst_fetch_unit_pkg::DEF_RESET_PC,
  parameter logic [31:0] IRQ_VECTOR = inst_fetch_unit_pkg::DEF_IRQ_VECTOR,
  parameter logic [31:0] EXC_VECTOR = inst_fetch_unit_pkg::DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        exc_i,
  input  logic        irq_i,
  output logic [31:0] pc_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic [31:0] epc_o,
  output logic        epc_we_o
);

  import inst_fetch_unit_pkg::*;

  logic [INST_ADDR_BUS-1:0] r_pc;
  logic [INST_ADDR_BUS-1:0] r_pend_pc;
  logic [INST_ADDR_BUS-1:0] r_epc;
  logic                     r_ce;
  logic                     r_pend_v;
  logic                     r_epc_we;

  logic [INST_ADDR_BUS-1:0] w_pc_nxt;
  logic [INST_ADDR_BUS-1:0] w_pend_pc_nxt;
  logic [INST_ADDR_BUS-1:0] w_epc_nxt;
  logic [INST_ADDR_BUS-1:0] w_redir_tgt;
  logic                     w_pend_v_nxt;
  logic                     w_epc_we_nxt;
  logic                     w_ifid_hold;
  logic                     w_ifid_bubble;
  logic                     w_irq_take;

  assign w_redir_tgt = word_align(redirect_pc_i);

  // PC[31] is the supervisor flag: no nesting. Interrupts also wait while a
  // redirect is in flight so the EPC never points at a wrong-path fetch.
  assign w_irq_take = irq_i & ~r_pc[31] & ~redirect_i & ~r_pend_v;

  always_comb begin
    w_pc_nxt      = r_pc;
    w_pend_v_nxt  = r_pend_v;
    w_pend_pc_nxt = r_pend_pc;
    w_epc_nxt     = r_epc;
    w_epc_we_nxt  = 1'b0;
    w_ifid_hold   = 1'b1;
    w_ifid_bubble = 1'b0;
    if (r_ce == CHIP_ENABLE) begin
      if (exc_i) begin
        w_pc_nxt      = EXC_VECTOR;
        w_pend_v_nxt  = 1'b0;
        w_ifid_hold   = 1'b0;
        w_ifid_bubble = 1'b1;
      end else if (w_irq_take) begin
        // The fetch at r_pc is squashed and re-executed on return via EPC.
        w_pc_nxt      = IRQ_VECTOR;
        w_epc_nxt     = r_pc;
        w_epc_we_nxt  = 1'b1;
        w_ifid_hold   = 1'b0;
        w_ifid_bubble = 1'b1;
      end else if (stall_i) begin
        // Park the target; a newer redirect overwrites an older one.
        if (redirect_i) begin
          w_pend_v_nxt  = 1'b1;
          w_pend_pc_nxt = w_redir_tgt;
        end
      end else if (r_pend_v) begin
        w_pc_nxt      = r_pend_pc;
        w_pend_v_nxt  = 1'b0;
        w_ifid_hold   = 1'b0;
        w_ifid_bubble = 1'b1;
      end else if (redirect_i) begin
        w_pc_nxt      = w_redir_tgt;
        w_ifid_hold   = 1'b0;
        w_ifid_bubble = 1'b1;
      end else begin
        w_pc_nxt      = r_pc + 32'd4;
        w_ifid_hold   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_ce      <= CHIP_DISABLE;
      r_pend_v  <= 1'b0;
      r_pend_pc <= ZERO_WORD;
      r_epc     <= ZERO_WORD;
      r_epc_we  <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_ce      <= CHIP_ENABLE;
      r_pend_v  <= w_pend_v_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      r_epc     <= w_epc_nxt;
      r_epc_we  <= w_epc_we_nxt;
    end
  end

  inst_fetch_unit_if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hold     (w_ifid_hold),
    .i_bubble   (w_ifid_bubble),
    .i_pc       (r_pc),
    .i_inst     (rom_data_i),
    .o_id_pc    (id_pc_o),
    .o_id_inst  (id_inst_o),
    .o_id_valid (id_valid_o)
  );

  // The supervisor bit selects privilege only; the ROM sees a 31-bit space.
  assign rom_addr_o = {1'b0, r_pc[30:0]};
  assign rom_ce_o   = r_ce;
  assign pc_o       = r_pc;
  assign epc_o      = r_epc;
  assign epc_we_o   = r_epc_we;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Purpose : self-checking bench for inst_fetch_unit (vector table, corner sequences, random).
// Latency : checks sampled 1 time unit after each rising edge.
// Backpressure: stall_i driven by table rows and randomly.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] rom_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        exc_i;
  logic        irq_i;
  logic [31:0] pc_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic [31:0] epc_o;
  logic        epc_we_o;

  int n_pass  = 0;
  int n_total = 0;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_addr_o    (rom_addr_o),
    .rom_ce_o      (rom_ce_o),
    .rom_data_i    (rom_data_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .exc_i         (exc_i),
    .irq_i         (irq_i),
    .pc_o          (pc_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_valid_o    (id_valid_o),
    .epc_o         (epc_o),
    .epc_we_o      (epc_we_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: a distinct nonzero word per address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  assign rom_data_i = rom_ce_o ? rom_word(rom_addr_o) : 32'h0;

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_epc;
  logic        m_ce, m_id_valid, m_epc_we;
  logic [31:0] m_pend_q[$];   // at most one parked redirect target

  task automatic model_reset();
    m_pc = 32'h0; m_ce = 1'b0; m_pend_q.delete();
    m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
    m_epc = 32'h0; m_epc_we = 1'b0;
  endtask

  task automatic model_bubble();
    m_id_pc = m_pc; m_id_inst = 32'h0; m_id_valid = 1'b0;
  endtask

  // One rising edge, evaluated from the state and inputs present before it.
  task automatic model_edge();
    logic [31:0] tgt;
    tgt = {redirect_pc_i[31:2], 2'b00};
    m_epc_we = 1'b0;
    if (!m_ce) begin
      m_ce = 1'b1;
    end else if (exc_i) begin
      model_bubble();
      m_pc = 32'h8000_0008;
      m_pend_q.delete();
    end else if (irq_i && !m_pc[31] && !redirect_i && m_pend_q.size() == 0) begin
      model_bubble();
      m_epc = m_pc; m_epc_we = 1'b1;
      m_pc = 32'h8000_0004;
    end else if (stall_i) begin
      if (redirect_i) begin
        m_pend_q.delete();
        m_pend_q.push_back(tgt);
      end
    end else if (m_pend_q.size() != 0) begin
      model_bubble();
      m_pc = m_pend_q.pop_front();
    end else if (redirect_i) begin
      model_bubble();
      m_pc = tgt;
    end else begin
      m_id_pc = m_pc;
      m_id_inst = rom_word({1'b0, m_pc[30:0]});
      m_id_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},       pc_o,       m_pc);
    check({tag, ".rom_addr"}, rom_addr_o, {1'b0, m_pc[30:0]});
    check({tag, ".rom_ce"},   {31'h0, rom_ce_o},   {31'h0, m_ce});
    check({tag, ".id_pc"},    id_pc_o,    m_id_pc);
    check({tag, ".id_inst"},  id_inst_o,  m_id_inst);
    check({tag, ".id_valid"}, {31'h0, id_valid_o}, {31'h0, m_id_valid});
    check({tag, ".epc"},      epc_o,      m_epc);
    check({tag, ".epc_we"},   {31'h0, epc_we_o},   {31'h0, m_epc_we});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    else model_reset();
    check_model(tag);
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                       input logic e, input logic q);
    stall_i = s; redirect_i = r; redirect_pc_i = rpc; exc_i = e; irq_i = q;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall, redir, exc, irq;
    logic [31:0] rpc;
    logic [31:0] e_pc, e_id_pc;
    logic        e_valid, e_we;
    logic [31:0] e_epc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic e, input logic q,
                              input logic [31:0] rpc, input logic [31:0] pc,
                              input logic [31:0] idpc, input logic v, input logic we,
                              input logic [31:0] epc);
    vec_t t;
    t.stall = s; t.redir = r; t.exc = e; t.irq = q; t.rpc = rpc;
    t.e_pc = pc; t.e_id_pc = idpc; t.e_valid = v; t.e_we = we; t.e_epc = epc;
    return t;
  endfunction

  localparam int NV = 24;
  vec_t tbl[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    //          stall redir exc irq rpc            pc             id_pc          v  we epc
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_0004, 32'h0000_0000, 1, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_0008, 32'h0000_0004, 1, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_000C, 32'h0000_0008, 1, 0, 32'h0);
    tbl[3]  = mk(0, 1, 0, 0, 32'h0000_0040, 32'h0000_0040, 32'h0000_000C, 0, 0, 32'h0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_0044, 32'h0000_0040, 1, 0, 32'h0);
    tbl[5]  = mk(0, 1, 0, 0, 32'h0000_000C, 32'h0000_000C, 32'h0000_0044, 0, 0, 32'h0);
    tbl[6]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_0010, 32'h0000_000C, 1, 0, 32'h0);
    tbl[7]  = mk(1, 0, 0, 0, 32'h0,         32'h0000_0010, 32'h0000_000C, 1, 0, 32'h0);
    tbl[8]  = mk(1, 0, 0, 0, 32'h0,         32'h0000_0010, 32'h0000_000C, 1, 0, 32'h0);
    tbl[9]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_0014, 32'h0000_0010, 1, 0, 32'h0);
    tbl[10] = mk(0, 0, 0, 0, 32'h0,         32'h0000_0018, 32'h0000_0014, 1, 0, 32'h0);
    tbl[11] = mk(1, 1, 0, 0, 32'h0000_00C8, 32'h0000_0018, 32'h0000_0014, 1, 0, 32'h0);
    tbl[12] = mk(1, 0, 0, 0, 32'h0,         32'h0000_0018, 32'h0000_0014, 1, 0, 32'h0);
    tbl[13] = mk(1, 0, 0, 0, 32'h0,         32'h0000_0018, 32'h0000_0014, 1, 0, 32'h0);
    tbl[14] = mk(0, 0, 0, 0, 32'h0,         32'h0000_00C8, 32'h0000_0018, 0, 0, 32'h0);
    tbl[15] = mk(0, 0, 0, 0, 32'h0,         32'h0000_00CC, 32'h0000_00C8, 1, 0, 32'h0);
    tbl[16] = mk(0, 1, 0, 0, 32'h0000_0023, 32'h0000_0020, 32'h0000_00CC, 0, 0, 32'h0);
    tbl[17] = mk(0, 0, 0, 1, 32'h0,         32'h8000_0004, 32'h0000_0020, 0, 1, 32'h20);
    tbl[18] = mk(0, 0, 0, 1, 32'h0,         32'h8000_0008, 32'h8000_0004, 1, 0, 32'h20);
    tbl[19] = mk(0, 1, 0, 1, 32'h0000_0020, 32'h0000_0020, 32'h8000_0008, 0, 0, 32'h20);
    tbl[20] = mk(0, 0, 0, 1, 32'h0,         32'h8000_0004, 32'h0000_0020, 0, 1, 32'h20);
    tbl[21] = mk(0, 1, 1, 1, 32'h0000_0100, 32'h8000_0008, 32'h8000_0004, 0, 0, 32'h20);
    tbl[22] = mk(0, 1, 0, 0, 32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h8000_0008, 0, 0, 32'h20);
    tbl[23] = mk(0, 0, 0, 0, 32'h0,         32'h8000_0000, 32'h7FFF_FFFC, 1, 0, 32'h20);

    // ---- reset: 5 cycles low, chip enable must stay off ----
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0);
    model_reset();
    for (int i = 0; i < 5; i++) step($sformatf("reset%0d", i));
    rst_n = 1'b1;
    step("ce_up");

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      logic [31:0] exp_inst;
      drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].exc, tbl[i].irq);
      @(posedge clk);
      #1;
      model_edge();
      exp_inst = tbl[i].e_valid ? rom_word({1'b0, tbl[i].e_id_pc[30:0]}) : 32'h0;
      check($sformatf("vec%0d.pc", i),       pc_o,       tbl[i].e_pc);
      check($sformatf("vec%0d.rom_addr", i), rom_addr_o, {1'b0, tbl[i].e_pc[30:0]});
      check($sformatf("vec%0d.id_pc", i),    id_pc_o,    tbl[i].e_id_pc);
      check($sformatf("vec%0d.id_inst", i),  id_inst_o,  exp_inst);
      check($sformatf("vec%0d.id_valid", i), {31'h0, id_valid_o}, {31'h0, tbl[i].e_valid});
      check($sformatf("vec%0d.epc_we", i),   {31'h0, epc_we_o},   {31'h0, tbl[i].e_we});
      check($sformatf("vec%0d.epc", i),      epc_o,      tbl[i].e_epc);
      check_model($sformatf("vec%0d.model", i));
    end

    // ---- async reset while a redirect is parked ----
    drive(1, 1, 32'h0000_0300, 0, 0);
    step("park");
    drive(1, 0, 32'h0, 0, 0);
    step("park_hold");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.pc",       pc_o,       32'h0);
    check("async_rst.rom_ce",   {31'h0, rom_ce_o},   32'h0);
    check("async_rst.id_valid", {31'h0, id_valid_o}, 32'h0);
    check("async_rst.id_inst",  id_inst_o,  32'h0);
    check("async_rst.epc",      epc_o,      32'h0);
    check_model("async_rst");
    drive(0, 0, 32'h0, 0, 0);
    step("rst_hold0");
    step("rst_hold1");
    rst_n = 1'b1;
    step("rst_ce_up");
    step("rst_first");
    check("pend_lost.pc", pc_o, 32'h0000_0004);

    // ---- randomized run against the model ----
    for (int i = 0; i < 500; i++) begin
      drive(($urandom % 4) == 0,
            ($urandom % 5) == 0,
            $urandom & 32'h8000_03FF,
            ($urandom % 40) == 0,
            ($urandom % 6) == 0);
      step($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
